uni2bin_acc_8b: RTL and testbench



---
 rtl/uni2bin_pkg.sv | 15 +
 rtl/uni2bin_wincnt.sv | 31 +++
 rtl/uni2bin_acc_8b.sv | 74 +++++++
 tb/tb_uni2bin_acc_8b.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uni2bin_pkg.sv
// Shared configuration for the unary-to-binary window accumulator.
// Optional feature macro: BIPOLAR_EN (result is ones minus half window, signed).
package uni2bin_pkg;

  // Window length exponent: one window is 2^INWD enabled cycles.
  localparam int unsigned INWD = 8;

  // Result word: unsigned count, or two's-complement bipolar value.
`ifdef BIPOLAR_EN
  typedef logic signed [INWD:0] result_t;
`else
  typedef logic [INWD:0] result_t;
`endif

endpackage

// File: rtl/uni2bin_wincnt.sv
// Enable-gated window sample counter with synchronous restart.
// lastSample flags an enabled, non-restart cycle on the final sample slot.
module uni2bin_wincnt
  import uni2bin_pkg::*;
#(
  parameter int unsigned CW = INWD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          start,
  output logic [CW-1:0] wcnt,
  output logic          lastSample
);

  // Sample position in the current window; a restart with a live sample
  // counts that sample as slot 0, so the counter lands on 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (start) begin
      wcnt <= enable ? CW'(1) : '0;
    end else if (enable) begin
      wcnt <= wcnt + CW'(1);
    end
  end

  // Window-close event; a restart always suppresses it.
  assign lastSample = enable & ~start & (wcnt == {CW{1'b1}});

endmodule

// File: rtl/uni2bin_acc_8b.sv
// Unary bitstream to binary converter: counts ones over back-to-back windows
// of 2^INWD enabled cycles and publishes each count with a one-cycle strobe.
// Optional feature macro: BIPOLAR_EN (binOut = ones - 2^(INWD-1), signed).
module uni2bin_acc_8b
  import uni2bin_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    enable,
  input  logic    start,
  input  logic    bitIn,
  output result_t binOut,
  output logic    outValid,
  output logic    busy
);

  localparam int unsigned AW = INWD + 1;

  logic [INWD-1:0] wcnt;
  logic            last_sample;
  logic [INWD:0]   acc;
  logic [INWD:0]   sum_c;
  result_t         res_c;

  uni2bin_wincnt #(
    .CW (INWD)
  ) u_wincnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .start      (start),
    .wcnt       (wcnt),
    .lastSample (last_sample)
  );

  // Running count including the current sample; cannot exceed 2^INWD.
  assign sum_c = acc + AW'(bitIn);

  // Map the closing count to the published result format.
`ifdef BIPOLAR_EN
  localparam logic [INWD:0] HALF_WIN = AW'(1) << (INWD - 1);
  assign res_c = result_t'(sum_c - HALF_WIN);
`else
  assign res_c = result_t'(sum_c);
`endif

  // Ones accumulator: restart reseeds with the live sample, close clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (start) begin
      acc <= enable ? AW'(bitIn) : '0;
    end else if (enable) begin
      acc <= last_sample ? '0 : sum_c;
    end
  end

  // Result register and completion strobe, loaded only on window close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binOut   <= '0;
      outValid <= 1'b0;
    end else begin
      outValid <= last_sample;
      if (last_sample) begin
        binOut <= res_c;
      end
    end
  end

  // Busy is a pure decode of the registered window position.
  assign busy = (wcnt != '0);

endmodule

// File: tb/tb_uni2bin_acc_8b.sv
// Directed bench for uni2bin_acc_8b; expected values are hand-computed
// for both the unsigned build and the BIPOLAR_EN build.
module tb_uni2bin_acc_8b;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;
  logic start  = 1'b0;
  logic bitIn  = 1'b0;
  logic outValid;
  logic busy;

`ifdef BIPOLAR_EN
  logic signed [8:0] binOut;
  localparam int EXP_ALL1  = 128;
  localparam int EXP_77    = -51;
  localparam int EXP_START = -127;
  localparam int EXP_ZERO  = -128;
`else
  logic [8:0] binOut;
  localparam int EXP_ALL1  = 256;
  localparam int EXP_77    = 77;
  localparam int EXP_START = 1;
  localparam int EXP_ZERO  = 0;
`endif

  int checks   = 0;
  int failures = 0;
  int pulses;
  int en_cnt;
  int iter;

  uni2bin_acc_8b dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .start    (start),
    .bitIn    (bitIn),
    .binOut   (binOut),
    .outValid (outValid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bin_val();
    return int'(binOut);
  endfunction

  // 8-bit first-dimension Sobol point: bit reversal of the index.
  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = x[7-k];
    return r;
  endfunction

  // Drive one cycle's inputs, then land on the following negedge.
  task automatic cyc(input logic en, input logic b, input logic st);
    enable = en;
    bitIn  = b;
    start  = st;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_binout", bin_val(), 0);
    check("rst_valid", int'(outValid), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // All-ones window.
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      pulses += int'(outValid);
    end
    check("ones_early_valid", pulses, 0);
    check("ones_busy_mid", int'(busy), 1);
    cyc(1'b1, 1'b1, 1'b0);
    check("ones_valid", int'(outValid), 1);
    check("ones_binout", bin_val(), EXP_ALL1);
    check("ones_busy_clr", int'(busy), 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("ones_valid_single", int'(outValid), 0);
    check("ones_hold", bin_val(), EXP_ALL1);

    // Two back-to-back Sobol windows for value 77.
    for (int w = 0; w < 2; w++) begin
      pulses = 0;
      for (int i = 0; i < 255; i++) begin
        cyc(1'b1, rev8(8'(i)) < 8'd77, 1'b0);
        pulses += int'(outValid);
      end
      check("sobol_early_valid", pulses, 0);
      cyc(1'b1, rev8(8'd255) < 8'd77, 1'b0);
      check("sobol_valid", int'(outValid), 1);
      check("sobol_binout", bin_val(), EXP_77);
    end

    // Random enable gaps; disabled cycles carry junk bitIn.
    pulses = 0;
    en_cnt = 0;
    iter   = 0;
    while (en_cnt < 256 && iter < 4000) begin
      logic e;
      logic b;
      e = 1'($urandom_range(0, 1));
      b = e ? 1'b1 : 1'($urandom_range(0, 1));
      cyc(e, b, 1'b0);
      if (e) en_cnt++;
      if (en_cnt < 256) pulses += int'(outValid);
      iter++;
    end
    check("gap_enabled_count", en_cnt, 256);
    check("gap_early_valid", pulses, 0);
    check("gap_valid", int'(outValid), 1);
    check("gap_binout", bin_val(), EXP_ALL1);

    // Restart on the last sample slot: no close, new window from there.
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      pulses += int'(outValid);
    end
    cyc(1'b1, 1'b1, 1'b1);
    pulses += int'(outValid);
    check("start_no_valid", pulses, 0);
    check("start_binout_kept", bin_val(), EXP_ALL1);
    check("start_busy", int'(busy), 1);
    for (int i = 0; i < 254; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      pulses += int'(outValid);
    end
    check("start_early_valid", pulses, 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("start_valid", int'(outValid), 1);
    check("start_binout", bin_val(), EXP_START);

    // Asynchronous reset mid-window, then an all-zero window.
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b0);
    check("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_binout", bin_val(), 0);
    check("arst_valid", int'(outValid), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      pulses += int'(outValid);
    end
    check("zero_early_valid", pulses, 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("zero_valid", int'(outValid), 1);
    check("zero_binout", bin_val(), EXP_ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
